// File: rtl/seg7_pkg.sv
// Shared constants and glyph table for the 7447-style seven-segment decoder.
// All values here are active-high: a 1 means the segment is lit.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_ALL   = 7'b1111111;

  // 7447 glyphs: 6 has no top bar, 9 has no bottom bar, 10..14 are the odd TTL shapes.
  function automatic logic [SEG_W-1:0] glyph(input logic [3:0] code);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    case (code)
      4'd0:  seg = 7'b1111110;
      4'd1:  seg = 7'b0110000;
      4'd2:  seg = 7'b1101101;
      4'd3:  seg = 7'b1111001;
      4'd4:  seg = 7'b0110011;
      4'd5:  seg = 7'b1011011;
      4'd6:  seg = 7'b0011111;
      4'd7:  seg = 7'b1110000;
      4'd8:  seg = 7'b1111111;
      4'd9:  seg = 7'b1110011;
      4'd10: seg = 7'b0001101;
      4'd11: seg = 7'b0011001;
      4'd12: seg = 7'b0100011;
      4'd13: seg = 7'b1001011;
      4'd14: seg = 7'b0001111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_rom.sv
// Combinational 4-to-7 lookup returning active-high segment patterns.
module seg7_rom
  import seg7_pkg::*;
(
  input  logic [3:0]       code_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = glyph(code_i);
  end

endmodule

// File: rtl/behave_7447.sv
// Registered BCD-to-7-segment decoder with lamp-test, blanking and ripple blanking.
// Output polarity is chosen by ACTIVE_LOW; inversion happens only at the register input.
module behave_7447
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       myInput,
  input  logic             lamp_test,
  input  logic             blank_in,
  input  logic             ripple_blank_in,
  output logic [SEG_W-1:0] myOutput,
  output logic             ripple_blank_out
);

  localparam logic [SEG_W-1:0] SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [SEG_W-1:0] romSeg;
  logic [SEG_W-1:0] segHigh;
  logic [SEG_W-1:0] seg_d, seg_q;
  logic             rbo_d, rbo_q;

  seg7_rom u_rom (
    .code_i (myInput),
    .seg_o  (romSeg)
  );

  // Blanking beats lamp test, which beats zero suppression, which beats decode.
  always_comb begin
    segHigh = SEG_BLANK;
    rbo_d   = 1'b0;
    if (blank_in) begin
      segHigh = SEG_BLANK;
    end else if (lamp_test) begin
      segHigh = SEG_ALL;
    end else if (ripple_blank_in && (myInput == 4'd0)) begin
      segHigh = SEG_BLANK;
      rbo_d   = 1'b1;
    end else begin
      segHigh = romSeg;
    end
    seg_d = ACTIVE_LOW ? ~segHigh : segHigh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      rbo_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      rbo_q <= rbo_d;
    end
  end

  assign myOutput         = seg_q;
  assign ripple_blank_out = rbo_q;

endmodule

// File: tb/tb_behave_7447.sv
// Directed bench for behave_7447: one active-low and one active-high instance
// share the same stimulus; outputs are sampled 1ns after each rising edge.
module tb_behave_7447;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] myInput;
  logic       lamp_test;
  logic       blank_in;
  logic       ripple_blank_in;
  logic [6:0] segLow, segHigh;
  logic       rboLow, rboHigh;

  int errors = 0;
  int checks = 0;

  // Hand-written active-high glyphs, indexed by code.
  logic [6:0] glyphTab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b0001101, 7'b0011001,
    7'b0100011, 7'b1001011, 7'b0001111, 7'b0000000
  };

  always #5 clk = ~clk;

  behave_7447 #(.ACTIVE_LOW(1'b1)) dutLow (
    .clk              (clk),
    .rst              (rst),
    .myInput          (myInput),
    .lamp_test        (lamp_test),
    .blank_in         (blank_in),
    .ripple_blank_in  (ripple_blank_in),
    .myOutput         (segLow),
    .ripple_blank_out (rboLow)
  );

  behave_7447 #(.ACTIVE_LOW(1'b0)) dutHigh (
    .clk              (clk),
    .rst              (rst),
    .myInput          (myInput),
    .lamp_test        (lamp_test),
    .blank_in         (blank_in),
    .ripple_blank_in  (ripple_blank_in),
    .myOutput         (segHigh),
    .ripple_blank_out (rboHigh)
  );

  // Drive inputs on the falling edge, then sample 1ns past the next rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] code,
                               input logic lt, input logic bi, input logic rbi);
    @(negedge clk);
    rst             = r;
    myInput         = code;
    lamp_test       = lt;
    blank_in        = bi;
    ripple_blank_in = rbi;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] seg, input logic rbo,
                             input logic [6:0] expSeg, input logic expRbo);
    checks++;
    assert ({seg, rbo} === {expSeg, expRbo}) else begin
      errors++;
      $error("[TB] FAIL %s: seg=%b rbo=%b, expected seg=%b rbo=%b",
             tag, seg, rbo, expSeg, expRbo);
    end
  endtask

  initial begin
    rst = 1'b1; myInput = 4'd3; lamp_test = 1'b0; blank_in = 1'b0; ripple_blank_in = 1'b0;

    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_low", segLow, rboLow, 7'b1111111, 1'b0);
    checkOutput("reset_high", segHigh, rboHigh, 7'b0000000, 1'b0);

    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("code3_low", segLow, rboLow, 7'b0000110, 1'b0);
    checkOutput("code3_high", segHigh, rboHigh, 7'b1111001, 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("sweep%0d_low", i), segLow, rboLow, ~glyphTab[i], 1'b0);
      checkOutput($sformatf("sweep%0d_high", i), segHigh, rboHigh, glyphTab[i], 1'b0);
    end

    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("spot0", segLow, rboLow, 7'b0000001, 1'b0);
    applyStimulus(1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    checkOutput("spot15", segLow, rboLow, 7'b1111111, 1'b0);
    applyStimulus(1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("spot8", segLow, rboLow, 7'b0000000, 1'b0);

    applyStimulus(1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    checkOutput("lamp_test", segLow, rboLow, 7'b0000000, 1'b0);
    applyStimulus(1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
    checkOutput("blank_over_lt", segLow, rboLow, 7'b1111111, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("blank_over_rbi", segLow, rboLow, 7'b1111111, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("lt_over_rbi", segLow, rboLow, 7'b0000000, 1'b0);

    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("rbi_zero", segLow, rboLow, 7'b1111111, 1'b1);
    checkOutput("rbi_zero_high", segHigh, rboHigh, 7'b0000000, 1'b1);
    applyStimulus(1'b0, 4'd8, 1'b0, 1'b0, 1'b1);
    checkOutput("rbi_eight", segLow, rboLow, 7'b0000000, 1'b0);

    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("latency_pre", segLow, rboLow, 7'b0000001, 1'b0);
    @(negedge clk);
    myInput = 4'd15;
    #2;
    checkOutput("latency_hold", segLow, rboLow, 7'b0000001, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("latency_update", segLow, rboLow, 7'b1111111, 1'b0);

    applyStimulus(1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_midreset", segLow, rboLow, 7'b0000000, 1'b0);
    applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 1'b1);
    checkOutput("midreset_low", segLow, rboLow, 7'b1111111, 1'b0);
    checkOutput("midreset_high", segHigh, rboHigh, 7'b0000000, 1'b0);
    applyStimulus(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset2", segLow, rboLow, 7'b0010010, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
